// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon-128 plaintext/ciphertext stream path:
// rate geometry, 10* padding constants and the packer state encoding.
package ascon_pkg;

  localparam int          RATE_BYTES = 8;
  localparam logic [7:0]  PAD_BYTE   = 8'h80;
  localparam logic [63:0] PAD_ONLY_BLOCK = {PAD_BYTE, 56'h0};

  typedef enum logic {FILL, PAD} pack_state_t;

  // Keep the first n lanes of acc (lane 0 = [63:56]), put PAD_BYTE in lane n,
  // zero everything after it. n == RATE_BYTES returns the full word.
  function automatic logic [63:0] pad_block(input logic [63:0] acc, input logic [3:0] n);
    logic [63:0] r;
    logic [3:0]  lane;
    r = '0;
    for (int i = 0; i < RATE_BYTES; i++) begin
      lane = 4'(i);
      if (lane < n)
        r[63-8*i -: 8] = acc[63-8*i -: 8];
      else if (lane == n)
        r[63-8*i -: 8] = PAD_BYTE;
    end
    return r;
  endfunction

endpackage

// File: rtl/ascon_pad_packer.sv
// Packs a byte stream big-endian into 64-bit Ascon rate blocks, applies 10*
// padding and reports the real byte count of each block for later truncation.
module ascon_pad_packer
  import ascon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [7:0]  s_tdata,
  input  logic        s_tlast,
  input  logic        empty_msg,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [63:0] m_tdata,
  output logic        m_tlast,
  output logic [3:0]  m_bytes,
  output logic        busy
);

  pack_state_t state;
  logic [2:0]  cnt;
  logic [63:0] acc;
  logic [63:0] acc_wr;
  logic        out_free;
  logic        accept;

  assign out_free = !m_tvalid || m_tready;
  assign s_tready = (state == FILL) && out_free;
  assign accept   = s_tvalid && s_tready;
  assign busy     = (cnt != 3'd0) || (state == PAD) || m_tvalid;

  always_comb begin
    acc_wr = acc;
    for (int i = 0; i < RATE_BYTES; i++) begin
      if (3'(i) == cnt)
        acc_wr[63-8*i -: 8] = s_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      cnt      <= 3'd0;
      acc      <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_bytes  <= 4'd0;
    end else begin
      // A completed handshake frees the register; any load below re-arms it.
      if (m_tready)
        m_tvalid <= 1'b0;

      if (accept) begin
        if (cnt == 3'd7) begin
          m_tvalid <= 1'b1;
          m_tdata  <= acc_wr;
          m_tlast  <= 1'b0;
          m_bytes  <= 4'd8;
          cnt      <= 3'd0;
          acc      <= '0;
          if (s_tlast)
            state <= PAD;
        end else if (s_tlast) begin
          m_tvalid <= 1'b1;
          m_tdata  <= pad_block(acc_wr, {1'b0, cnt} + 4'd1);
          m_tlast  <= 1'b1;
          m_bytes  <= {1'b0, cnt} + 4'd1;
          cnt      <= 3'd0;
          acc      <= '0;
        end else begin
          acc <= acc_wr;
          cnt <= cnt + 3'd1;
        end
      end else if (state == PAD) begin
        if (out_free) begin
          m_tvalid <= 1'b1;
          m_tdata  <= PAD_ONLY_BLOCK;
          m_tlast  <= 1'b1;
          m_bytes  <= 4'd0;
          state    <= FILL;
        end
      end else if (empty_msg && cnt == 3'd0) begin
        // An empty message is just the pad-only block; park in PAD if the
        // output register is still occupied.
        if (out_free) begin
          m_tvalid <= 1'b1;
          m_tdata  <= PAD_ONLY_BLOCK;
          m_tlast  <= 1'b1;
          m_bytes  <= 4'd0;
        end else begin
          state <= PAD;
        end
      end
    end
  end

endmodule
